channel_carrier_mixer: RTL and testbench



---
 rtl/channel_carrier_mixer_if.sv | 31 +++
 rtl/channel_carrier_mixer.sv | 139 +++++++++++++
 tb/tb_channel_carrier_mixer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/channel_carrier_mixer_if.sv
// rtl/channel_carrier_mixer_if.sv - sample/NCO control inputs and mixer/accumulator outputs of one channel
interface channel_carrier_mixer_if #(
  parameter int ADC_W   = 2,
  parameter int PHASE_W = 32,
  parameter int ACC_W   = 16
);
  logic                 sample_valid;
  logic [ADC_W-1:0]     adc;
  logic [PHASE_W-1:0]   freq_code;
  logic                 phase_load;
  logic [PHASE_W-1:0]   phase_init;
  logic                 dump;
  logic [PHASE_W-1:0]   phase;
  logic                 product_valid;
  logic [ADC_W+2:0]     i_product;
  logic [ADC_W+2:0]     q_product;
  logic                 acc_valid;
  logic [ACC_W-1:0]     i_acc;
  logic [ACC_W-1:0]     q_acc;
  logic                 acc_ovf;

  modport master (
    output sample_valid, adc, freq_code, phase_load, phase_init, dump,
    input  phase, product_valid, i_product, q_product, acc_valid, i_acc, q_acc, acc_ovf
  );

  modport slave (
    input  sample_valid, adc, freq_code, phase_load, phase_init, dump,
    output phase, product_valid, i_product, q_product, acc_valid, i_acc, q_acc, acc_ovf
  );
endinterface

// File: rtl/channel_carrier_mixer.sv
// rtl/channel_carrier_mixer.sv - carrier NCO, quarter-wave cos/sin mixer and saturating integrate-and-dump
// Assumes ADC_W >= 2 and ACC_W >= ADC_W+3 so a single product always fits the accumulator.
module channel_carrier_mixer #(
  parameter int ADC_W   = 2,
  parameter int PHASE_W = 32,
  parameter int ACC_W   = 16
) (
  input logic                  clk,
  input logic                  reset,
  channel_carrier_mixer_if.slave bus
);
  localparam int S_W   = ADC_W + 1;
  localparam int P_W   = ADC_W + 3;
  localparam int SUM_W = ACC_W + 1;

  function automatic logic signed [2:0] cos_lut(input logic [4:0] k);
    logic [2:0] idx;
    logic [1:0] mag;
    idx = k[3] ? ~k[2:0] : k[2:0];
    case (idx)
      3'd0, 3'd1, 3'd2: mag = 2'd3;
      3'd3, 3'd4:       mag = 2'd2;
      3'd5, 3'd6:       mag = 2'd1;
      default:          mag = 2'd0;
    endcase
    cos_lut = (k[4] ^ k[3]) ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // Returns {clamped, value}; the sum carries one guard bit above ACC_W.
  function automatic logic [ACC_W:0] sat(input logic [SUM_W-1:0] v);
    if (v[SUM_W-1] != v[SUM_W-2])
      sat = {1'b1, v[SUM_W-1], {(ACC_W-1){~v[SUM_W-1]}}};
    else
      sat = {1'b0, v[ACC_W-1:0]};
  endfunction

  logic [PHASE_W-1:0]    phase_q, phase_d, cur_phase;
  logic signed [S_W-1:0] s0;

  logic signed [S_W-1:0] s1_q;
  logic [4:0]            k1_q;
  logic                  v1_q, d1_q;

  logic signed [2:0]     cos_v, sin_v;
  logic signed [P_W-1:0] s_ext, cos_ext, sin_ext;
  logic signed [P_W-1:0] i_prod_q, q_prod_q;
  logic                  pv_q, d2_q;

  logic [ACC_W-1:0]      ai_q, aq_q, ai_d, aq_d;
  logic                  ovf_q, ovf_d;
  logic [SUM_W-1:0]      i_sum, q_sum;
  logic [ACC_W:0]        i_sat, q_sat;

  logic [ACC_W-1:0]      i_acc_q, q_acc_q;
  logic                  acc_ovf_q, acc_valid_q;

  always_comb begin
    cur_phase = bus.phase_load ? bus.phase_init : phase_q;
    phase_d   = cur_phase + (bus.sample_valid ? bus.freq_code : '0);
    s0        = $signed({1'b0, bus.adc[ADC_W-2:0], 1'b1});
    if (bus.adc[ADC_W-1])
      s0 = -s0;
  end

  always_comb begin
    cos_v   = cos_lut(k1_q);
    sin_v   = cos_lut(k1_q - 5'd8);
    s_ext   = {{2{s1_q[S_W-1]}}, s1_q};
    cos_ext = {{(P_W-3){cos_v[2]}}, cos_v};
    sin_ext = {{(P_W-3){sin_v[2]}}, sin_v};
  end

  // A dump restarts the epoch, so the dump-cycle product adds onto zero.
  always_comb begin
    i_sum = (d2_q ? '0 : {ai_q[ACC_W-1], ai_q}) + {{(SUM_W-P_W){i_prod_q[P_W-1]}}, i_prod_q};
    q_sum = (d2_q ? '0 : {aq_q[ACC_W-1], aq_q}) + {{(SUM_W-P_W){q_prod_q[P_W-1]}}, q_prod_q};
    i_sat = sat(i_sum);
    q_sat = sat(q_sum);
    ai_d  = d2_q ? '0 : ai_q;
    aq_d  = d2_q ? '0 : aq_q;
    ovf_d = d2_q ? 1'b0 : ovf_q;
    if (pv_q) begin
      ai_d  = i_sat[ACC_W-1:0];
      aq_d  = q_sat[ACC_W-1:0];
      ovf_d = ovf_d | i_sat[ACC_W] | q_sat[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      s1_q        <= '0;
      k1_q        <= '0;
      v1_q        <= 1'b0;
      d1_q        <= 1'b0;
      i_prod_q    <= '0;
      q_prod_q    <= '0;
      pv_q        <= 1'b0;
      d2_q        <= 1'b0;
      ai_q        <= '0;
      aq_q        <= '0;
      ovf_q       <= 1'b0;
      i_acc_q     <= '0;
      q_acc_q     <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      s1_q        <= s0;
      k1_q        <= cur_phase[PHASE_W-1 -: 5];
      v1_q        <= bus.sample_valid;
      d1_q        <= bus.dump;
      pv_q        <= v1_q;
      d2_q        <= d1_q;
      if (v1_q) begin
        i_prod_q <= s_ext * cos_ext;
        q_prod_q <= s_ext * sin_ext;
      end
      ai_q        <= ai_d;
      aq_q        <= aq_d;
      ovf_q       <= ovf_d;
      acc_valid_q <= d2_q;
      if (d2_q) begin
        i_acc_q   <= ai_q;
        q_acc_q   <= aq_q;
        acc_ovf_q <= ovf_q;
      end
    end
  end

  assign bus.phase         = phase_q;
  assign bus.product_valid = pv_q;
  assign bus.i_product     = i_prod_q;
  assign bus.q_product     = q_prod_q;
  assign bus.acc_valid     = acc_valid_q;
  assign bus.i_acc         = i_acc_q;
  assign bus.q_acc         = q_acc_q;
  assign bus.acc_ovf       = acc_ovf_q;
endmodule

// File: tb/tb_channel_carrier_mixer.sv
// tb/tb_channel_carrier_mixer.sv - scoreboard bench for channel_carrier_mixer with directed vectors
module tb_channel_carrier_mixer;
  localparam int ADC_W = 2;
  localparam int PHASE_W = 32;
  localparam int ACC_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  channel_carrier_mixer_if #(.ADC_W(ADC_W), .PHASE_W(PHASE_W), .ACC_W(ACC_W)) bus ();

  channel_carrier_mixer #(.ADC_W(ADC_W), .PHASE_W(PHASE_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // round(3*cos(2*pi*(k+0.5)/32)) and round(3*sin(...)), tabulated by hand
  int COS_T[32] = '{3, 3, 3, 2, 2, 1, 1, 0, 0, -1, -1, -2, -2, -3, -3, -3,
                    -3, -3, -3, -2, -2, -1, -1, 0, 0, 1, 1, 2, 2, 3, 3, 3};
  int SIN_T[32] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 2, 2, 1, 1, 0,
                    0, -1, -1, -2, -2, -3, -3, -3, -3, -3, -3, -2, -2, -1, -1, 0};

  typedef struct { int c; int i; int q; } prod_t;
  typedef struct { int c; int i; int q; int o; } acc_t;
  prod_t pq[$];
  acc_t  aq[$];
  logic [PHASE_W-1:0] m_phase = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sdec(input logic [1:0] a);
    case (a)
      2'b00:   return 1;
      2'b01:   return 3;
      2'b10:   return -1;
      default: return -3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.product_valid) begin
      if (pq.size() == 0) begin
        chk("unexpected_product_valid", 1, 0);
      end else begin
        prod_t p;
        p = pq.pop_front();
        chk("product_cycle", cyc, p.c);
        chk("i_product", int'($signed(bus.i_product)), p.i);
        chk("q_product", int'($signed(bus.q_product)), p.q);
      end
    end
    if (bus.acc_valid) begin
      if (aq.size() == 0) begin
        chk("unexpected_acc_valid", 1, 0);
      end else begin
        acc_t a;
        a = aq.pop_front();
        chk("acc_cycle", cyc, a.c);
        chk("i_acc", int'($signed(bus.i_acc)), a.i);
        chk("q_acc", int'($signed(bus.q_acc)), a.q);
        chk("acc_ovf", int'(bus.acc_ovf), a.o);
      end
    end
  end

  task automatic drive(input logic sv, input logic [1:0] a, input logic ld,
                       input logic [31:0] init, input logic [31:0] fc, input logic dp);
    prod_t p;
    int k;
    bus.sample_valid = sv;
    bus.adc          = a;
    bus.phase_load   = ld;
    bus.phase_init   = init;
    bus.freq_code    = fc;
    bus.dump         = dp;
    if (ld) m_phase = init;
    if (sv) begin
      k = int'(m_phase[31:27]);
      p.c = cyc + 2;
      p.i = sdec(a) * COS_T[k];
      p.q = sdec(a) * SIN_T[k];
      pq.push_back(p);
      m_phase = m_phase + fc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic exp_acc(input int i, input int q, input int o);
    acc_t a;
    a.c = cyc + 3;
    a.i = i;
    a.q = q;
    a.o = o;
    aq.push_back(a);
  endtask

  task automatic reset_dut();
    idle(4);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    m_phase = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase"}, int'(bus.phase), 0);
    chk({tag, "_i_product"}, int'(bus.i_product), 0);
    chk({tag, "_q_product"}, int'(bus.q_product), 0);
    chk({tag, "_product_valid"}, int'(bus.product_valid), 0);
    chk({tag, "_i_acc"}, int'(bus.i_acc), 0);
    chk({tag, "_q_acc"}, int'(bus.q_acc), 0);
    chk({tag, "_acc_valid"}, int'(bus.acc_valid), 0);
    chk({tag, "_acc_ovf"}, int'(bus.acc_ovf), 0);
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.adc          = '0;
    bus.phase_load   = 1'b0;
    bus.phase_init   = '0;
    bus.freq_code    = '0;
    bus.dump         = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // I product at phase 0
    drive(1'b1, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
    // quarter and half turn
    drive(1'b1, 2'b10, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 2'b11, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(3);

    // full table sweep
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, 2'(a), 1'b1, 32'h0, 32'h0800_0000, 1'b0);
      for (int j = 1; j < 32; j++) drive(1'b1, 2'(a), 1'b0, 32'h0, 32'h0800_0000, 1'b0);
    end
    idle(3);

    // NCO load without a sample holds, then wraps on the next sample
    drive(1'b0, 2'b00, 1'b1, 32'hFFFF_FFF0, 32'h20, 1'b0);
    chk("phase_after_load", int'(bus.phase), int'(32'hFFFF_FFF0));
    drive(1'b1, 2'b00, 1'b0, 32'h0, 32'h20, 1'b0);
    chk("phase_wrap", int'(bus.phase), 32'h10);
    drive(1'b1, 2'b01, 1'b1, 32'h1234_0000, 32'h0000_0100, 1'b0);
    chk("phase_load_plus_step", int'(bus.phase), 32'h1234_0100);

    // epochs: normal, saturating, recovery, back-to-back, quadrature
    reset_dut();
    exp_acc(0, 0, 0);
    drive(1'b1, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1);
    for (int j = 1; j < 10; j++) drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_acc(90, 0, 0);
    drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int j = 11; j < 25; j++) drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_acc(127, 0, 1);
    drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int j = 26; j < 30; j++) drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_acc(45, 0, 0);
    drive(1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_acc(9, 0, 0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    exp_acc(0, 0, 0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    drive(1'b1, 2'b10, 1'b1, 32'h4000_0000, 32'h0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_acc(0, -9, 0);
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    idle(5);

    // reset one cycle after a dump drops it
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
    reset = 1'b1;
    idle(2);
    check_all_zero("midreset");
    reset = 1'b0;
    idle(1);
    drive(1'b1, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);
    for (int j = 0; j < 4; j++) begin
      chk("no_acc_after_reset", int'(bus.acc_valid), 0);
      idle(1);
    end

    idle(4);
    chk("pending_products", pq.size(), 0);
    chk("pending_accs", aq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
